// File: rtl/axis_to_fifo_packer.sv
`default_nettype none
// ============================================================================
// Module      : axis_to_fifo_packer
// Description : Packs an AXI4-Stream packet into FIFO words: a TUSER header,
//               then data bytes with interleaved strobes. Optional counters
//               are enabled by AXIS_TO_FIFO_PACKER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_to_fifo_packer #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    localparam int C_PACKED_WIDTH      = C_S_AXIS_DATA_WIDTH + C_S_AXIS_DATA_WIDTH/8
) (
    input  logic                              axi_aclk,
    input  logic                              axi_areset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic                              fifo_wr_en,
    output logic [C_PACKED_WIDTH-1:0]         fifo_dout,
    input  logic                              fifo_full,
    input  logic                              sw_rst,
    output logic                              err_strb
`ifdef AXIS_TO_FIFO_PACKER_STATS_EN
    ,
    output logic [31:0]                       pkt_count,
    output logic [47:0]                       byte_count
`endif
);

    localparam int c_BYTES = C_S_AXIS_DATA_WIDTH / 8;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DATA = 2'd1;
    localparam logic [1:0] c_PAD  = 2'd2;

    logic [1:0]                     r_state;
    logic [1:0]                     w_next_state;
    logic                           w_wr_cond;
    logic                           w_hs;
    logic                           w_strb_full;
    logic [C_S_AXIS_DATA_WIDTH-1:0] w_hdr_data;
    logic [C_S_AXIS_DATA_WIDTH-1:0] w_word_data;
    logic [c_BYTES-1:0]             w_word_strb;

    assign w_strb_full = &s_axis_tstrb;
    assign w_hs        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        w_hdr_data                           = '0;
        w_hdr_data[C_S_AXIS_TUSER_WIDTH-1:0] = s_axis_tuser;
    end

    // State register
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state <= c_IDLE;
        end else if (sw_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (s_axis_tvalid && !fifo_full) begin
                    w_next_state = c_DATA;
                end
            end
            c_DATA: begin
                if (w_hs && s_axis_tlast) begin
                    w_next_state = w_strb_full ? c_PAD : c_IDLE;
                end
            end
            c_PAD: begin
                if (!fifo_full) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic; a full-strobe last beat needs a PAD word so the reader
    // sees a partial strobe as the end of packet.
    always_comb begin
        s_axis_tready = 1'b0;
        w_wr_cond     = 1'b0;
        w_word_data   = '0;
        w_word_strb   = '0;
        case (r_state)
            c_IDLE: begin
                w_wr_cond   = s_axis_tvalid;
                w_word_data = w_hdr_data;
                w_word_strb = '1;
            end
            c_DATA: begin
                s_axis_tready = !fifo_full && !axi_areset;
                w_wr_cond     = s_axis_tvalid;
                w_word_data   = s_axis_tdata;
                w_word_strb   = s_axis_tlast ? s_axis_tstrb : '1;
            end
            c_PAD: begin
                w_wr_cond = 1'b1;
            end
            default: begin
                w_wr_cond = 1'b0;
            end
        endcase
        fifo_wr_en = w_wr_cond && !fifo_full && !axi_areset;
    end

    for (genvar i = 0; i < c_BYTES; i++) begin : g_pack
        assign fifo_dout[9*i +: 8] = w_word_data[8*i +: 8];
        assign fifo_dout[9*i + 8]  = w_word_strb[i];
    end

    // A non-last partial strobe would terminate the packet early at the reader
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            err_strb <= 1'b0;
        end else if (sw_rst) begin
            err_strb <= 1'b0;
        end else if (w_hs && !s_axis_tlast && !w_strb_full) begin
            err_strb <= 1'b1;
        end
    end

`ifdef AXIS_TO_FIFO_PACKER_STATS_EN
    logic        w_last_word;
    logic [47:0] w_strb_pop;

    assign w_last_word = fifo_wr_en &&
                         ((r_state == c_DATA && s_axis_tlast && !w_strb_full) ||
                          (r_state == c_PAD));

    always_comb begin
        w_strb_pop = '0;
        for (int i = 0; i < c_BYTES; i++) begin
            w_strb_pop = w_strb_pop + {47'd0, s_axis_tstrb[i]};
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            pkt_count  <= '0;
            byte_count <= '0;
        end else if (sw_rst) begin
            pkt_count  <= '0;
            byte_count <= '0;
        end else begin
            if (w_last_word) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (w_hs) begin
                byte_count <= byte_count + w_strb_pop;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/axis_to_fifo_packer.md
Name: axis_to_fifo_packer

Overview:
- Transmit-side counterpart of the FIFO-to-AXIS replay reader: accepts an AXI4-Stream packet and writes it into a FIFO in the packed word format that the reader consumes.
- Per packet it writes one TUSER header word, then data words with each byte's strobe interleaved beside it.
- The FIFO itself (sync or async) sits outside this block. This block drives only the FIFO write side and runs on one clock.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, slave stream data width in bits; multiple of 8, and greater than or equal to C_S_AXIS_TUSER_WIDTH.
- C_S_AXIS_TUSER_WIDTH, 128, slave stream TUSER width in bits.
- C_PACKED_WIDTH, C_S_AXIS_DATA_WIDTH+C_S_AXIS_DATA_WIDTH/8, FIFO word width; derived, never overridden.

Ports:
- axi_aclk  in  1  the single clock.
- axi_areset  in  1  asynchronous active-high reset.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  stream data.
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  per-packet metadata, sampled on the first beat.
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_dout  out  C_PACKED_WIDTH  packed FIFO word.
- fifo_full  in  1  FIFO full flag.
- sw_rst  in  1  synchronous software reset, equivalent in effect to axi_areset.
- err_strb  out  1  sticky protocol-error flag.

Behaviour:
- Packing rule, byte i: fifo_dout[9i+7:9i] = tdata[8i+7:8i]; fifo_dout[9i+8] = strb[i].
- Header word format:
  - Byte fields carry s_axis_tuser, zero-extended to C_S_AXIS_DATA_WIDTH.
  - All strobe bits = 1.
- Combinational write path: fifo_wr_en = (write condition) and !fifo_full. fifo_wr_en is never asserted while fifo_full = 1.
- State IDLE:
  - s_axis_tready = 0.
  - If tvalid and !fifo_full: write the header word from the current s_axis_tuser, then go to DATA.
  - The beat itself is not consumed in IDLE.
- State DATA:
  - s_axis_tready = !fifo_full.
  - On handshake (tvalid & tready): write the packed beat.
  - Go to IDLE if tlast and tstrb is not all ones.
  - Go to PAD if tlast and tstrb is all ones.
  - Otherwise stay in DATA.
- State PAD:
  - s_axis_tready = 0.
  - When !fifo_full: write an all-zero word, which is the terminator the reader needs because it detects end of packet from a partial strobe. Then go to IDLE.
- Non-last beat with partial tstrb:
  - Strobe bits are written as all ones; data is unchanged.
  - err_strb is set and held until reset or sw_rst.
  - This prevents premature termination at the reader.
- tlast with tstrb all zero: written as-is; it is a valid terminator.
- Single-beat packet: header word, then the data word; plus a PAD word if that beat's strobe is full.
- fifo_full asserted mid-packet: tready drops in the same cycle, no beat is lost, and the state is held.
- Throughput: 1 beat per cycle in DATA. Header and PAD each cost 1 extra cycle.
- Reset values (axi_areset asynchronously, sw_rst on the next edge):
  - state = IDLE, err_strb = 0.
  - Outputs: s_axis_tready = 0, fifo_wr_en = 0.
  - Any partial packet is abandoned without a terminator; upstream is expected to flush the FIFO together with the reset.

Optional Feature:
- Macro: AXIS_TO_FIFO_PACKER_STATS_EN.
- When defined, the block adds these outputs:
  - pkt_count[31:0]: increments when a packet's final FIFO word is written (terminating data word or PAD word).
  - byte_count[47:0]: adds popcount(tstrb) on each accepted beat.
  - Both counters wrap modulo 2^width and clear on reset or sw_rst.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- 3-beat packet, tuser=0xABCD, final tstrb=0x0000FFFF (256-bit), FIFO never full -> 4 writes: header (byte fields = 0xABCD, strobes all 1), two full-strobe words, one word whose low 16 strobe bits are set; back in IDLE.
- 2-beat packet with final tstrb=all ones -> 4 writes, the last an all-zero PAD word; s_axis_tready = 0 during the PAD cycle.
- fifo_full held for 5 cycles after the header write -> tready = 0 and fifo_wr_en = 0 throughout; the next beat is written exactly once after full drops.
- Middle beat with tstrb=0x0F (non-last) -> strobe bits written as all ones; err_strb = 1 and stays set across the next packet until sw_rst.
- axi_areset pulsed mid-packet, then a new 1-beat packet with tstrb=0x1 -> outputs go to 0 immediately on reset; afterwards exactly header plus one data word are written.
- With AXIS_TO_FIFO_PACKER_STATS_EN defined: after the first two scenarios, pkt_count = 2 and byte_count = 32+32+16+32+32 = 144.
